// File: rtl/ifm_scan_pkg.sv
// Shared codes for the IFM scan controller and the IFM buffer that consumes its shift codes.
package ifm_scan_pkg;

  localparam int COORD_W = 8;

  // Buffer shift codes; the IFM buffer decodes these same values.
  localparam logic [2:0] RD_ALL   = 3'b111;
  localparam logic [2:0] RD_RIGHT = 3'b001;
  localparam logic [2:0] RD_DOWN  = 3'b010;
  localparam logic [2:0] RD_LEFT  = 3'b100;
  localparam logic [2:0] RD_KEEP  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WAIT_PE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/ifm_scan_step.sv
// Combinational snake-order step: given the current 3x3 window position and direction,
// produces the next window, the fetch needed to reach it, or flags the last window.
module ifm_scan_step
  import ifm_scan_pkg::*;
#(
  parameter int IFM_W = 8,
  parameter int IFM_H = 8
) (
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  input  logic               i_east,
  output logic [2:0]         o_kind,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output logic               o_east,
  output logic [COORD_W-1:0] o_frow,
  output logic [COORD_W-1:0] o_fcol,
  output logic               o_last
);

  localparam logic [COORD_W-1:0] COL_END = COORD_W'(IFM_W - 3);
  localparam logic [COORD_W-1:0] ROW_END = COORD_W'(IFM_H - 3);

  always_comb begin
    o_kind = RD_KEEP;
    o_row  = i_row;
    o_col  = i_col;
    o_east = i_east;
    o_frow = i_row;
    o_fcol = i_col;
    o_last = 1'b0;
    if (i_east && (i_col < COL_END)) begin
      o_kind = RD_RIGHT;
      o_col  = i_col + 8'd1;
      o_fcol = i_col + 8'd3;
    end else if (!i_east && (i_col != '0)) begin
      o_kind = RD_LEFT;
      o_col  = i_col - 8'd1;
      o_fcol = i_col - 8'd1;
    end else if (i_row < ROW_END) begin
      // Row end: step down one row, fetch the new bottom row, reverse direction.
      o_kind = RD_DOWN;
      o_row  = i_row + 8'd1;
      o_east = ~i_east;
      o_frow = i_row + 8'd3;
    end else begin
      o_last = 1'b1;
    end
  end

endmodule

// File: rtl/ifm_scan_ctrl.sv
// Snake-order 3x3 window scan controller for the IFM buffer.
// Optional IFM_SCAN_CTRL_STATS_EN adds stall_cnt/win_cnt statistics outputs.
module ifm_scan_ctrl
  import ifm_scan_pkg::*;
#(
  parameter int IFM_W = 8,
  parameter int IFM_H = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_req,
  output logic [2:0]         rd_kind,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  input  logic               rd_valid,
  output logic [2:0]         ifm_read,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  input  logic               pe_done,
  output logic               busy,
  output logic               done
`ifdef IFM_SCAN_CTRL_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        win_cnt
`endif
);

  state_e               r_state;
  state_e               w_next;
  logic [COORD_W-1:0]   r_row, r_col, r_frow, r_fcol;
  logic                 r_east;
  logic [2:0]           r_kind;

  logic [2:0]           w_kind;
  logic [COORD_W-1:0]   w_row, w_col, w_frow, w_fcol;
  logic                 w_east, w_last;
  logic                 w_accept, w_advance;

  ifm_scan_step #(
    .IFM_W (IFM_W),
    .IFM_H (IFM_H)
  ) u_step (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_east (r_east),
    .o_kind (w_kind),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_east (w_east),
    .o_frow (w_frow),
    .o_fcol (w_fcol),
    .o_last (w_last)
  );

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_advance = (r_state == ST_WAIT_PE) && pe_done && !w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rd_req    = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ifm_read  = RD_KEEP;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        if (rd_valid) begin
          ifm_read = r_kind;
          w_next   = ST_WAIT_PE;
        end
      end
      ST_WAIT_PE: begin
        win_valid = 1'b1;
        busy      = 1'b1;
        if (pe_done) w_next = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Window position, direction and pending fetch descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_east <= 1'b1;
      r_kind <= RD_ALL;
      r_frow <= '0;
      r_fcol <= '0;
    end else if (w_accept) begin
      r_row  <= '0;
      r_col  <= '0;
      r_east <= 1'b1;
      r_kind <= RD_ALL;
      r_frow <= '0;
      r_fcol <= '0;
    end else if (w_advance) begin
      r_row  <= w_row;
      r_col  <= w_col;
      r_east <= w_east;
      r_kind <= w_kind;
      r_frow <= w_frow;
      r_fcol <= w_fcol;
    end
  end

  assign rd_kind = r_kind;
  assign rd_row  = r_frow;
  assign rd_col  = r_fcol;
  assign win_row = r_row;
  assign win_col = r_col;

`ifdef IFM_SCAN_CTRL_STATS_EN
  logic [15:0] r_stall_cnt, r_win_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_stall_cnt <= '0;
      r_win_cnt   <= '0;
    end else if (r_state == ST_FETCH) begin
      if (!rd_valid && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (rd_valid) r_win_cnt <= r_win_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign win_cnt   = r_win_cnt;
`endif

endmodule
